demux_stream_1ton: RTL and testbench
====================================

# demux_stream_1toN

Parametrised, registered 1-to-N stream demultiplexer, the next generation of the combinational 1:8 demux. It routes each input beat to one of N output channels, either by an explicit select or by a round-robin pointer. Each channel has a valid/ready handshake and a one-entry output register. It sits between a single producer and N independent consumers in the datapath.

## Interface
Parameters:
- WIDTH, 8, data bits per beat
- N, 8, output channel count (2..64; need not be a power of 2)
- SELW, $clog2(N), select width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a beat
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  WIDTH  beat payload
- sel  input  SELW  target channel; used when mode=0
- mode  input  1  0 = select-steered, 1 = round-robin
- out_valid  output  N  per-channel beat present
- out_ready  input  N  per-channel consumer ready
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- drop_err  output  1  one-cycle pulse when an out-of-range beat is discarded

## Operation
- Target channel t:
  - mode=0: t = sel.
  - mode=1: t = rr_ptr.
  - sel and mode are sampled only in the accept cycle.
- Channel k is free when out_valid[k]=0 or out_ready[k]=1.
- in_ready = (target in range and free(t)), or (mode=0 and sel>=N).
- A beat is accepted when in_valid & in_ready.
- Valid accept: out_data[t] <= in_data and out_valid[t] <= 1 at the next edge.
  - In mode=1 only, rr_ptr advances to (rr_ptr+1) mod N, wrapping N-1 to 0.
- Out-of-range beat (mode=0, sel>=N): accepted and discarded, drop_err=1 next cycle; no channel or rr_ptr change.
- Drain: out_valid[k] & out_ready[k] with no new write to k clears out_valid[k]. out_data[k] holds its last value.
- Same-channel write and drain in one cycle: out_valid[k] stays 1 and out_data[k] takes the new beat (full throughput, no bubble).
- Round-robin is strict: if channel rr_ptr is busy, in_ready=0. Other free channels are not skipped.
- mode toggles take effect on the next accept. rr_ptr keeps its value in mode=0.
- Rules for upstream and downstream:
  - in_data must stay stable while in_valid & ~in_ready.
  - out_valid[k] never drops without out_ready[k].
  - in_ready depends combinationally on out_ready; there is no combinational path from in_valid to in_ready.

## Timing
- Latency: an accept at edge n makes out_valid[t]=1 and out_data[t] valid after edge n.
- Throughput: one beat per cycle, given the target channel is free.
- Reset values, applied when rst=1 at an edge:
  - out_valid=0
  - out_data=0
  - rr_ptr=0
  - drop_err=0
  - drop counter=0
- Reset mid-stream discards every buffered beat. During reset, in_ready is 0 and no accepts happen.
- drop_err is high for exactly one cycle per discarded beat. Back-to-back drops keep it high.

## Configuration
- DEMUX_DROP_CNT_EN defined:
  - Adds output drop_cnt (16 bits), which counts discarded beats and saturates at 16'hFFFF.
  - drop_cnt resets to 0 and updates on the same edge that raises drop_err.
- Undefined: no drop_cnt port and no counter logic. drop_err still exists.

## Structure
- Package demux_pkg:
  - mode_e enum: MODE_SEL=1'b0, MODE_RR=1'b1.
  - DROP_CNT_W=16 constant.
- Sub-module demux_chan_reg: the one-entry channel buffer (wr_en, wr_data, ready, valid, data), instantiated N times in a generate loop.
- The top level holds target decode, in_ready, rr_ptr, drop_err and the optional counter.

## Test plan
- Reset: hold rst for 2 cycles -> out_valid=0, out_data=0, drop_err=0, in_ready=0 during reset.
- Steered sweep: WIDTH=8, N=8, mode=0, all out_ready=1, in_data=8'hA0+k, sel=k for k=0..7 -> out_valid has a single bit k set one cycle later, with channel k data = 8'hA0+k.
- Backpressure: out_ready[3]=0, two beats to sel=3 -> first beat held in channel 3, in_ready=0 on the second. Raise out_ready[3] -> the second beat is accepted in the same cycle with no bubble.
- Round-robin wrap: mode=1, N=5, 7 beats with all ready -> channels 0,1,2,3,4,0,1 in order, rr_ptr=2 at the end. Hold ch2 not-ready -> in_ready=0 and there is no skip to ch3.
- Out-of-range: N=5, mode=0, sel=6 -> in_ready=1, no out_valid change, drop_err pulses once. With DEMUX_DROP_CNT_EN, drop_cnt=1.
- Mid-stream reset: channels 1 and 4 full, assert rst -> all out_valid=0 next cycle, rr_ptr=0, drop_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
package demux_pkg;

  // Steering mode sampled in the accept cycle.
  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Width of the optional saturating discard counter.
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output buffer for a single demux channel. A write always wins
// over a drain, so write+drain in the same cycle keeps the channel full.
module demux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Hold one beat; a write loads it, a consumer handshake releases it.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload is reset too, because out_data is architecturally visible and must read 0 after reset.
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer: steers each beat to a channel by an
// explicit select or by a strict round-robin pointer. Out-of-range selects
// are accepted and discarded, flagged on drop_err.
// Optional feature: define DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               drop_err
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  mode_e           cur_mode;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] target;
  logic            target_in_range;
  logic            target_free;
  logic            out_of_range;
  logic            accept;
  logic            drop;
  logic [N-1:0]    chan_free;
  logic [N-1:0]    wr_en;

  assign cur_mode = mode_e'(mode);

  // Target decode, in_ready and per-channel write enables.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    target          = (cur_mode == MODE_RR) ? rr_ptr : sel;
    chan_free       = ~out_valid | out_ready;
    target_in_range = int'(target) < N;
    target_free     = 1'b0;
    wr_en           = '0;
    // The pointer never leaves 0..N-1, so only a select can be out of range.
    out_of_range    = (cur_mode == MODE_SEL) && !target_in_range;
    // A loop instead of chan_free[target] keeps non-power-of-2 N from indexing past the vector.
    for (int k = 0; k < N; k++) begin
      if (int'(target) == k) target_free = chan_free[k];
    end
    in_ready = !rst && ((target_in_range && target_free) || out_of_range);
    accept   = in_valid && in_ready;
    drop     = accept && out_of_range;
    for (int k = 0; k < N; k++) begin
      wr_en[k] = accept && (int'(target) == k);
    end
  end

  // Round-robin pointer advances only on round-robin accepts; drop_err pulses per discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= drop;
      if (accept && (cur_mode == MODE_RR)) begin
        rr_ptr <= (rr_ptr == SELW'(N - 1)) ? '0 : rr_ptr + SELW'(1);
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating count of discarded beats, updated on the edge that raises drop_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`endif

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en[k]),
      .wr_data(in_data),
      .ready  (out_ready[k]),
      .valid  (out_valid[k]),
      .data   (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Self-checking bench for demux_stream_1ton: one N=8 and one N=5 instance
// share the same stimulus and are each compared against a per-channel model.
module tb_demux_stream_1ton;

  localparam int W  = 8;
  localparam int NA = 8;
  localparam int NB = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [SW-1:0] sel;
  logic          mode;
  logic [NA-1:0] out_ready;

  logic           a_in_ready, b_in_ready;
  logic [NA-1:0]  a_out_valid;
  logic [NB-1:0]  b_out_valid;
  logic [NA*W-1:0] a_out_data;
  logic [NB*W-1:0] b_out_data;
  logic           a_drop_err, b_drop_err;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]    a_drop_cnt, b_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = N=8 instance, 1 = N=5 instance.
  bit         mv   [2][8];
  logic [7:0] md   [2][8];
  int         rr   [2];
  int         dcnt [2];
  bit         derr [2];
  int         nch  [2] = '{NA, NB};

  always #5 clk = ~clk;

  demux_stream_1ton #(.WIDTH(W), .N(NA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .sel(sel), .mode(mode), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .drop_err(a_drop_err)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(a_drop_cnt)
`endif
  );

  demux_stream_1ton #(.WIDTH(W), .N(NB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .sel(sel), .mode(mode), .out_valid(b_out_valid),
    .out_ready(out_ready[NB-1:0]), .out_data(b_out_data), .drop_err(b_drop_err)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Channel targeted this cycle by the steering rule.
  function automatic int model_target(int i);
    return mode ? rr[i] : int'(sel);
  endfunction

  // Handshake rule: target free, or an out-of-range select that gets discarded.
  function automatic bit model_ready(int i);
    int t = model_target(i);
    if (rst) return 1'b0;
    if (t < nch[i]) return !mv[i][t] || out_ready[t];
    return !mode;
  endfunction

  // Next state of the model after one clock edge with the current inputs.
  task automatic model_edge(int i);
    bit acc;
    int t;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        mv[i][k] = 1'b0;
        md[i][k] = '0;
      end
      rr[i] = 0; dcnt[i] = 0; derr[i] = 1'b0;
      return;
    end
    acc = in_valid && model_ready(i);
    t   = model_target(i);
    for (int k = 0; k < nch[i]; k++) begin
      if (mv[i][k] && out_ready[k]) mv[i][k] = 1'b0;
    end
    derr[i] = 1'b0;
    if (acc) begin
      if (t < nch[i]) begin
        mv[i][t] = 1'b1;
        md[i][t] = in_data;
        if (mode) rr[i] = (rr[i] + 1) % nch[i];
      end else begin
        derr[i] = 1'b1;
        if (dcnt[i] < 65535) dcnt[i]++;
      end
    end
  endtask

  function automatic logic [63:0] exp_valid(int i);
    logic [63:0] v = '0;
    for (int k = 0; k < nch[i]; k++) v[k] = mv[i][k];
    return v;
  endfunction

  function automatic logic [63:0] exp_data(int i);
    logic [63:0] v = '0;
    for (int k = 0; k < nch[i]; k++) v[k*8 +: 8] = md[i][k];
    return v;
  endfunction

  // One clock: check in_ready mid-cycle, advance model, check outputs after the edge.
  task automatic step(string tag);
    @(negedge clk);
    check({tag, " a.in_ready"}, 64'(a_in_ready), 64'(model_ready(0)));
    check({tag, " b.in_ready"}, 64'(b_in_ready), 64'(model_ready(1)));
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check({tag, " a.out_valid"}, 64'(a_out_valid), exp_valid(0));
    check({tag, " b.out_valid"}, 64'(b_out_valid), exp_valid(1));
    check({tag, " a.out_data"}, 64'(a_out_data), exp_data(0));
    check({tag, " b.out_data"}, 64'(b_out_data), exp_data(1));
    check({tag, " a.drop_err"}, 64'(a_drop_err), 64'(derr[0]));
    check({tag, " b.drop_err"}, 64'(b_drop_err), 64'(derr[1]));
`ifdef DEMUX_DROP_CNT_EN
    check({tag, " a.drop_cnt"}, 64'(a_drop_cnt), 64'(dcnt[0]));
    check({tag, " b.drop_cnt"}, 64'(b_drop_cnt), 64'(dcnt[1]));
`endif
  endtask

  initial begin
    // Reset held for two cycles with a pending beat.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; sel = '0; mode = 1'b0; out_ready = '1;
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // Steered sweep; on the N=5 instance selects 5..7 are discarded back-to-back.
    for (int k = 0; k < 8; k++) begin
      in_data = 8'(8'hA0 + k);
      sel     = SW'(k);
      step("sweep");
      check("sweep a.onehot", 64'(a_out_valid), 64'(1) << k);
    end
    in_valid = 1'b0;
    step("drop_end");

    // Backpressure on channel 3, then release with no bubble.
    in_valid = 1'b1; sel = 3'd3; out_ready = 8'hF7; in_data = 8'h31;
    step("bp_first");
    in_data = 8'h32;
    step("bp_second");
    out_ready = '1;
    step("bp_release");
    check("bp a.ch3_data", 64'(a_out_data[3*W +: W]), 64'(8'h32));

    // Round-robin wrap from a clean pointer.
    rst = 1'b1;
    step("rr_reset");
    rst = 1'b0; mode = 1'b1;
    for (int j = 0; j < 7; j++) begin
      in_data = 8'(8'hC0 + j);
      step("rr_wrap");
      check("rr_wrap b.onehot", 64'(b_out_valid), 64'(1) << (j % NB));
    end
    check("rr_wrap b.rr_ptr", 64'(u_dut_b.rr_ptr), 64'(2));
    check("rr_wrap a.rr_ptr", 64'(u_dut_a.rr_ptr), 64'(7));

    // Fill channel 2 via select (pointer must hold), then round-robin must stall on it.
    out_ready = '0; mode = 1'b0; sel = 3'd2; in_data = 8'hE2;
    step("rr_fill2");
    check("rr_fill2 b.rr_ptr", 64'(u_dut_b.rr_ptr), 64'(2));
    mode = 1'b1; out_ready = ~8'h04; in_data = 8'hE3;
    step("rr_strict");
    check("rr_strict b.ch3_empty", 64'(b_out_valid[3]), 64'(0));

    // Mid-stream reset with channels 1 and 4 full.
    rst = 1'b1;
    step("mid_pre");
    rst = 1'b0; out_ready = '0; mode = 1'b0; sel = 3'd1; in_data = 8'h11;
    step("mid_fill1");
    sel = 3'd4; in_data = 8'h44;
    step("mid_fill4");
    check("mid_full b.out_valid", 64'(b_out_valid), 64'(5'b10010));
    rst = 1'b1; sel = 3'd6;
    step("mid_reset");
    check("mid_reset a.out_valid", 64'(a_out_valid), 64'(0));
    check("mid_reset b.rr_ptr", 64'(u_dut_b.rr_ptr), 64'(0));
    rst = 1'b0;

    // Randomised traffic with occasional resets and mode flips.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      sel       = SW'($urandom);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      out_ready = 8'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
